// File: rtl/oldland_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its decode hook
// in execute.
package oldland_muldiv_pkg;

  // Operation select carried on the op port.
  localparam logic [2:0] MULDIV_OP_MUL   = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULHU = 3'd1;
  localparam logic [2:0] MULDIV_OP_MULHS = 3'd2;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'd4;
  localparam logic [2:0] MULDIV_OP_MODU  = 3'd5;
  localparam logic [2:0] MULDIV_OP_MOD   = 3'd6;
  localparam logic [2:0] MULDIV_OP_RSVD  = 3'd7;

  // ALU opcode that execute decodes to route an instruction to this unit.
  localparam logic [3:0] ALU_OPC_MULDIV = 4'hf;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  // Ops that work on operand magnitudes and re-apply the sign in FIX.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MULDIV_OP_MULHS) || (op == MULDIV_OP_DIV) || (op == MULDIV_OP_MOD);
  endfunction

  function automatic logic is_mul_op(input logic [2:0] op);
    return op <= MULDIV_OP_MULHS;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op >= MULDIV_OP_DIVU) && (op <= MULDIV_OP_MOD);
  endfunction

endpackage

// File: rtl/oldland_muldiv_sign.sv
// Combinational sign handling: operand magnitudes at issue time, and the
// sign fix-up plus result select applied after the iterative core.
module oldland_muldiv_sign
  import oldland_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  output logic               a_neg,
  output logic               b_neg,
  input  logic [2:0]         fix_op,
  input  logic               fix_a_neg,
  input  logic               fix_b_neg,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   rem,
  output logic [WIDTH-1:0]   fix_result
);

  logic               sgn;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  // Capture side: unsigned ops pass raw operands with no sign flags.
  always_comb begin
    sgn   = is_signed_op(op);
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Fix-up side: product/quotient negate on differing signs, remainder follows a.
  always_comb begin
    prod_s = (fix_a_neg ^ fix_b_neg) ? -prod : prod;
    quo_s  = (fix_a_neg ^ fix_b_neg) ? -quo  : quo;
    rem_s  = fix_a_neg ? -rem : rem;
    case (fix_op)
      MULDIV_OP_MUL:   fix_result = prod[WIDTH-1:0];
      MULDIV_OP_MULHU: fix_result = prod[2*WIDTH-1:WIDTH];
      MULDIV_OP_MULHS: fix_result = prod_s[2*WIDTH-1:WIDTH];
      MULDIV_OP_DIVU:  fix_result = quo;
      MULDIV_OP_DIV:   fix_result = quo_s;
      MULDIV_OP_MODU:  fix_result = rem;
      MULDIV_OP_MOD:   fix_result = rem_s;
      default:         fix_result = '0;
    endcase
  end

endmodule

// File: rtl/oldland_muldiv.sv
// Iterative multiply/divide unit beside the execute-stage ALU.
// Handshake: execute pulses start for one cycle while busy is low (IDLE or
// the DONE cycle); the op is accepted on that edge unless flush is also high.
// busy stays high until the DONE cycle, where done pulses for one cycle with
// result, rd_sel_out and div_zero valid. flush drops any in-flight op silently.
module oldland_muldiv
  import oldland_muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2,
  parameter int RD_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [RD_W-1:0]  rd_sel,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [RD_W-1:0]  rd_sel_out,
  output logic             div_zero,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH / MUL_BITS);
  localparam logic [CW-1:0] CNT_DIV = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [RD_W-1:0]    rd_q, rd_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  // opa: shifting multiplicand in MUL; dividend/quotient shift register in DIV.
  logic [2*WIDTH-1:0] opa_q, opa_d;
  // opb: shifting multiplier in MUL; divisor in DIV.
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   cap_a_mag, cap_b_mag;
  logic               cap_a_neg, cap_b_neg;
  logic [WIDTH-1:0]   fix_result;
  logic [WIDTH:0]     shifted, diff;
  logic [2*WIDTH-1:0] partial;

  oldland_muldiv_sign #(.WIDTH(WIDTH)) u_sign (
    .op         (op),
    .a          (a),
    .b          (b),
    .a_mag      (cap_a_mag),
    .b_mag      (cap_b_mag),
    .a_neg      (cap_a_neg),
    .b_neg      (cap_b_neg),
    .fix_op     (op_q),
    .fix_a_neg  (a_neg_q),
    .fix_b_neg  (b_neg_q),
    .prod       (acc_q),
    .quo        (opa_q[WIDTH-1:0]),
    .rem        (rem_q),
    .fix_result (fix_result)
  );

  // Next-state and datapath step for the FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    dz_d     = dz_q;

    shifted = {rem_q, opa_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    partial = opa_q * {{(2*WIDTH-MUL_BITS){1'b0}}, opb_q[MUL_BITS-1:0]};

    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (start && !flush) begin
          op_d    = op;
          rd_d    = rd_sel;
          a_neg_d = cap_a_neg;
          b_neg_d = cap_b_neg;
          opa_d   = {{WIDTH{1'b0}}, cap_a_mag};
          opb_d   = cap_b_mag;
          acc_d   = '0;
          rem_d   = '0;
          dz_d    = 1'b0;
          if (is_mul_op(op)) begin
            state_d = MD_MUL;
            cnt_d   = CNT_MUL;
          end else if (is_div_op(op)) begin
            if (b == '0) begin
              // Divide by zero finishes immediately: quotient all ones, remainder raw a.
              state_d  = MD_DONE;
              dz_d     = 1'b1;
              result_d = ((op == MULDIV_OP_DIVU) || (op == MULDIV_OP_DIV)) ? '1 : a;
            end else begin
              state_d = MD_DIV;
              cnt_d   = CNT_DIV;
            end
          end else begin
            state_d  = MD_DONE;
            result_d = '0;
          end
        end
      end
      MD_MUL: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = acc_q + partial;
          opa_d = opa_q << MUL_BITS;
          opb_d = opb_q >> MUL_BITS;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = MD_FIX;
        end
      end
      MD_DIV: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          // Restoring step: keep the trial subtraction only if it did not borrow.
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            opa_d = {{WIDTH{1'b0}}, opa_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            opa_d = {{WIDTH{1'b0}}, opa_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          result_d = fix_result;
          state_d  = MD_DONE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  // Outputs decode directly from the state register.
  always_comb begin
    busy       = (state_q != MD_IDLE) && (state_q != MD_DONE);
    done       = (state_q == MD_DONE);
    div_zero   = (state_q == MD_DONE) && dz_q;
    result     = result_q;
    rd_sel_out = rd_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_oldland_muldiv.sv
// Directed bench for oldland_muldiv at WIDTH=32, MUL_BITS=2, RD_W=4.
module tb_oldland_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  rd_sel;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  rd_sel_out;
  logic        div_zero;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  oldland_muldiv #(.WIDTH(32), .MUL_BITS(2), .RD_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .rd_sel     (rd_sel),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rd_sel_out (rd_sel_out),
    .div_zero   (div_zero),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [3:0] rr);
    op = o; a = aa; b = bb; rd_sel = rr; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns cycles from the start cycle to the done cycle (bounded).
  task automatic wait_done(input int c0, output int lat);
    lat = c0;
    while (done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_sel = '0;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (rd_sel_out !== 4'h0) begin bad++; $display("FAIL reset_rd got=%h want=0", rd_sel_out); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%0b want=0", div_zero); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_mul();
    int lat;
    start_op(3'd0, 32'h0001_0003, 32'h0002_0005, 4'h1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_busy got=%0b want=1", busy); end
    wait_done(1, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL mul_lat got=%0d want=18", lat); end
    total++; if (result !== 32'h000B_000F) begin bad++; $display("FAIL mul_res got=%h want=000b000f", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_busy_done got=%0b want=0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%0b want=0", done); end
    start_op(3'd1, 32'h0001_0003, 32'h0002_0005, 4'h2);
    wait_done(1, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL mulhu_lat got=%0d want=18", lat); end
    total++; if (result !== 32'h0000_0002) begin bad++; $display("FAIL mulhu_res got=%h want=00000002", result); end
    step();
    start_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 4'h3);
    wait_done(1, lat);
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulhs_res got=%h want=ffffffff", result); end
    step();
  endtask

  task automatic test_div();
    int lat;
    start_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'h4);
    wait_done(1, lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL div_lat got=%0d want=34", lat); end
    total++; if (result !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_res got=%h want=fffffffd", result); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_dz got=%0b want=0", div_zero); end
    step();
    start_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 4'h5);
    wait_done(1, lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL mod_lat got=%0d want=34", lat); end
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mod_res got=%h want=ffffffff", result); end
    step();
    start_op(3'd3, 32'd100, 32'd7, 4'hA);
    wait_done(1, lat);
    total++; if (result !== 32'd14) begin bad++; $display("FAIL divu_res got=%h want=0000000e", result); end
    total++; if (rd_sel_out !== 4'hA) begin bad++; $display("FAIL rd_sel_out got=%h want=a", rd_sel_out); end
    step();
    start_op(3'd5, 32'd100, 32'd7, 4'h6);
    wait_done(1, lat);
    total++; if (result !== 32'd2) begin bad++; $display("FAIL modu_res got=%h want=00000002", result); end
    step();
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(3'd3, 32'd100, 32'd0, 4'h7);
    wait_done(1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_divu_lat got=%0d want=1", lat); end
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_divu_res got=%h want=ffffffff", result); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_divu_flag got=%0b want=1", div_zero); end
    step();
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_flag_pulse got=%0b want=0", div_zero); end
    start_op(3'd5, 32'd100, 32'd0, 4'h8);
    wait_done(1, lat);
    total++; if (result !== 32'd100) begin bad++; $display("FAIL dz_modu_res got=%h want=00000064", result); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_modu_flag got=%0b want=1", div_zero); end
    step();
    start_op(3'd7, 32'd5, 32'd3, 4'h9);
    wait_done(1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL rsvd_lat got=%0d want=1", lat); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rsvd_res got=%h want=0", result); end
    step();
  endtask

  task automatic test_overflow();
    int lat;
    start_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'h1);
    wait_done(1, lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL ovf_div_lat got=%0d want=34", lat); end
    total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL ovf_div_res got=%h want=80000000", result); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL ovf_div_dz got=%0b want=0", div_zero); end
    step();
    start_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'h1);
    wait_done(1, lat);
    total++; if (result !== 32'h0) begin bad++; $display("FAIL ovf_mod_res got=%h want=0", result); end
    step();
  endtask

  task automatic test_start_while_busy();
    int lat;
    start_op(3'd0, 32'h0001_0003, 32'h0002_0005, 4'h2);
    repeat (4) step();
    op = 3'd3; a = 32'd100; b = 32'd7; rd_sel = 4'hC; start = 1'b1;
    step();
    start = 1'b0;
    total++; if (dbg_state !== 3'd1) begin bad++; $display("FAIL swb_state got=%0d want=1", dbg_state); end
    wait_done(6, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL swb_lat got=%0d want=18", lat); end
    total++; if (result !== 32'h000B_000F) begin bad++; $display("FAIL swb_res got=%h want=000b000f", result); end
    total++; if (rd_sel_out !== 4'h2) begin bad++; $display("FAIL swb_rd got=%h want=2", rd_sel_out); end
    step();
  endtask

  task automatic test_flush();
    int pulses;
    start_op(3'd3, 32'd100, 32'd7, 4'h3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b want=0", busy); end
    total++; if (result !== 32'h000B_000F) begin bad++; $display("FAIL flush_res got=%h want=000b000f", result); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL flush_no_done got=%0d want=0", pulses); end
    // flush and start together from IDLE: the start is dropped.
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%0b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(3'd0, 32'd3, 32'd4, 4'h1);
    wait_done(1, lat);
    total++; if (result !== 32'd12) begin bad++; $display("FAIL b2b_first_res got=%h want=0000000c", result); end
    start_op(3'd3, 32'd100, 32'd7, 4'hB);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b want=1", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done got=%0b want=0", done); end
    wait_done(1, lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_lat got=%0d want=34", lat); end
    total++; if (result !== 32'd14) begin bad++; $display("FAIL b2b_res got=%h want=0000000e", result); end
    total++; if (rd_sel_out !== 4'hB) begin bad++; $display("FAIL b2b_rd got=%h want=b", rd_sel_out); end
    step();
  endtask

  task automatic test_async_reset();
    int lat;
    start_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'h5);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got=%0b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL arst_res got=%h want=0", result); end
    #3 rst_n = 1'b1;
    step();
    start_op(3'd0, 32'd3, 32'd4, 4'h6);
    wait_done(1, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL arst_mul_lat got=%0d want=18", lat); end
    total++; if (result !== 32'd12) begin bad++; $display("FAIL arst_mul_res got=%h want=0000000c", result); end
    step();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_start_while_busy();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oldland_muldiv.md
Name: oldland_muldiv

Overview:
- Iterative multiply/divide unit that sits beside the execute-stage ALU.
- Execute issues an operation with a single-cycle start pulse and stalls the pipeline while busy is high.
- The unit returns the result, plus the destination register select, with a done pulse.
- Generalised in width and multiply radix.
- Adds signed/unsigned divide, remainder and high-half multiply, none of which the single-cycle ALU provides.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and at least 8.
- MUL_BITS, 2, multiplier bits retired per cycle; legal values 1, 2, 4; must divide WIDTH.
- RD_W, 4, width of the destination register select.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle issue strobe; ignored while busy
- op  in  3  operation: 0 MUL (low half), 1 MULHU, 2 MULHS, 3 DIVU, 4 DIV, 5 MODU, 6 MOD, 7 reserved
- a  in  WIDTH  first operand (dividend / multiplicand)
- b  in  WIDTH  second operand (divisor / multiplier)
- rd_sel  in  RD_W  destination register, captured at start
- flush  in  1  abort in-flight operation (exception/branch squash)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle completion pulse
- result  out  WIDTH  result; valid when done, held until the next accepted start
- rd_sel_out  out  RD_W  captured rd_sel; valid with done
- div_zero  out  1  pulses with done when a divide/mod op had b == 0

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, div_zero=0, result=0, rd_sel_out=0, all internal regs 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start with op 0-2 -> MUL; op 3-6 with b!=0 -> DIV; op 3-6 with b==0 -> DONE; op 7 -> DONE with result 0.
  - At start, capture op, rd_sel, |a|, |b| and the sign bits. Signed ops are MULHS, DIV and MOD; all others use the raw operands.
- MUL: shift-add of MUL_BITS bits per cycle, WIDTH/MUL_BITS cycles, accumulating into a 2*WIDTH product; then -> FIX.
- DIV: restoring divide, one quotient bit per cycle, WIDTH cycles; then -> FIX.
- FIX: one cycle. Apply signs:
  - MULHS: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ.
  - MOD: the remainder takes the sign of a.
  - Then select the low half, high half, quotient or remainder; -> DONE.
- DONE: done=1 for exactly one cycle, result and rd_sel_out driven; -> IDLE.
  - busy is deasserted in the DONE cycle, so execute can issue a new start in that same cycle. That start is accepted, IDLE is bypassed, and busy rises the next cycle.
- Latency from start to done:
  - MUL: WIDTH/MUL_BITS + 2 cycles.
  - Divide/mod: WIDTH + 2 cycles.
  - Divide by zero or op 7: 1 cycle.
- Divide by zero: quotient = all ones, remainder = a (raw); div_zero=1 with done.
- Signed overflow (DIV/MOD with a = most-negative, b = -1): quotient = most-negative, remainder = 0, no div_zero. This falls out of the magnitude datapath when it is WIDTH+1 bits wide internally, or is special-cased in FIX.
- A start while busy is ignored; no state change.
- flush in any non-IDLE state -> IDLE on the next edge, with no done and result unchanged. flush in the DONE cycle suppresses nothing, because done is already asserted.
- flush and start in the same cycle from IDLE: flush wins; the start is dropped.
- Async reset mid-operation: immediate return to the reset values; no done.
- Cycle counter width is clog2(WIDTH)+1; it counts down to zero. There is no wrap-around condition.

Decomposition:
- Shared package/defines file (oldland_defines.v) gets:
  - MULDIV_OP_* encodings (3-bit).
  - State encodings MD_IDLE/MD_MUL/MD_DIV/MD_FIX/MD_DONE.
  - ALU_OPC_MULDIV, which execute decodes to route to this unit.
- One natural sub-module, oldland_muldiv_sign: combinational abs/negate/select used at capture and in FIX.
- The FSM, counter and shift datapath stay in oldland_muldiv.

Test Plan:
- WIDTH=32, MUL_BITS=2: MUL a=0x0001_0003, b=0x0002_0005 -> done after 18 cycles, result=0x000B_000F; MULHU of the same -> 0x0000_0002.
- MULHS a=0xFFFF_FFFF (-1), b=0x0000_0002 -> result=0xFFFF_FFFF. DIV a=-7, b=2 -> 0xFFFF_FFFD (-3). MOD a=-7, b=2 -> 0xFFFF_FFFF (-1). Each divide op -> done after 34 cycles.
- DIVU a=100, b=0 -> done 1 cycle after start, result=0xFFFF_FFFF, div_zero=1. MODU a=100, b=0 -> result=100, div_zero=1.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> result=0x8000_0000, div_zero=0. MOD with the same operands -> 0.
- Pipeline/abort cases:
  - start DIVU mid-MUL -> ignored; the MUL result is unaffected.
  - flush at cycle 10 of a DIVU -> busy=0 the next cycle, no done pulse.
  - A start in the DONE cycle -> accepted, back-to-back ops.
  - rd_sel=0xA -> rd_sel_out=0xA on done.
- Assert rst_n low asynchronously mid-DIV, between clock edges -> busy, done and result are 0 immediately. Release, then MUL 3*4 -> 12.
